// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch-stage PC generator.
package pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam int unsigned DEF_STEP       = 4;

    // RUN: no redirect buffered. HOLD: a redirect seen during a stall is waiting.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control inputs and PC outputs of the fetch-stage PC generator.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_step1;
    logic [WIDTH-1:0] pc_step2;
    logic             redir_pending;
    logic             misalign;

    // Pipeline control side: drives requests, observes the PC.
    modport master (
        output stall, redir_valid, redir_target, exc_req, eret, epc,
        input  pc, pc_step1, pc_step2, redir_pending, misalign
    );

    // PC generator side.
    modport slave (
        input  stall, redir_valid, redir_target, exc_req, eret, epc,
        output pc, pc_step1, pc_step2, redir_pending, misalign
    );
endinterface

// File: rtl/pc_incr.sv
// Sequential successors of the PC: one and two instructions ahead, modulo 2^WIDTH.
module pc_incr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] step1_o,
    output logic [WIDTH-1:0] step2_o
);

    // Carry out is dropped on purpose; the PC wraps.
    always_comb begin
        step1_o = pc_i + WIDTH'(STEP);
        step2_o = pc_i + WIDTH'(2 * STEP);
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC register, redirect buffer and next-PC selection.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      STEP       = DEF_STEP
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] step1, step2;

    pc_incr #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_incr (
        .pc_i    (pc_q),
        .step1_o (step1),
        .step2_o (step2)
    );

    // Next-PC priority: exception, eret, stall (buffering), live redirect, buffered, +STEP.
    always_comb begin
        pc_d    = pc_q;
        buf_d   = buf_q;
        state_d = state_q;
        if (bus.exc_req) begin
            pc_d    = EXC_VECTOR;
            state_d = ST_RUN;
        end else if (bus.eret) begin
            pc_d    = bus.epc;
            state_d = ST_RUN;
        end else if (bus.stall) begin
            // Newest redirect seen during a stall wins.
            if (bus.redir_valid) begin
                buf_d   = bus.redir_target;
                state_d = ST_HOLD;
            end
        end else if (bus.redir_valid) begin
            pc_d    = bus.redir_target;
            state_d = ST_RUN;
        end else if (state_q == ST_HOLD) begin
            pc_d    = buf_q;
            state_d = ST_RUN;
        end else begin
            pc_d = step1;
        end
    end

    // State, PC and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs derive only from registered state.
    always_comb begin
        bus.pc            = pc_q;
        bus.pc_step1      = step1;
        bus.pc_step2      = step2;
        bus.redir_pending = (state_q == ST_HOLD);
        bus.misalign      = (pc_q % WIDTH'(STEP)) != '0;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen #(
        .WIDTH      (32),
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_PC),
        .STEP       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: the PC, plus an optional remembered redirect target.
    logic [31:0] m_pc;
    logic [31:0] m_saved[$];
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", bus.pc, m_pc);
            check("pc_step1", bus.pc_step1, m_pc + 32'd4);
            check("pc_step2", bus.pc_step2, m_pc + 32'd8);
            check("redir_pending", 32'(bus.redir_pending), 32'(m_saved.size() != 0));
            check("misalign", 32'(bus.misalign), 32'((m_pc % 4) != 0));
        end
    end

    // Apply one cycle of inputs, advance the model at the edge, return just after negedge.
    task automatic step(input logic rn, input logic st, input logic rv, input logic [31:0] tgt,
                        input logic ex, input logic er, input logic [31:0] ep);
        rst_n            = rn;
        bus.stall        = st;
        bus.redir_valid  = rv;
        bus.redir_target = tgt;
        bus.exc_req      = ex;
        bus.eret         = er;
        bus.epc          = ep;
        @(posedge clk);
        if (!rn) begin
            m_pc = RST_PC;
            m_saved.delete();
        end else if (ex) begin
            m_pc = EXC_PC;
            m_saved.delete();
        end else if (er) begin
            m_pc = ep;
            m_saved.delete();
        end else if (st) begin
            if (rv) begin
                m_saved.delete();
                m_saved.push_back(tgt);
            end
        end else if (rv) begin
            m_pc = tgt;
            m_saved.delete();
        end else if (m_saved.size() != 0) begin
            m_pc = m_saved.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (!rn) chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic run();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_target = '0;
        bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = '0;

        // Reset, then free-run.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rst_pc", bus.pc, 32'h0000_3000);
        check("rst_step2", bus.pc_step2, 32'h0000_3008);
        check("rst_pending", 32'(bus.redir_pending), 32'd0);
        run(); check("free1", bus.pc, 32'h0000_3004);
        run(); check("free2", bus.pc, 32'h0000_3008);
        run(); check("free3", bus.pc, 32'h0000_300C);
        run(); check("free4", bus.pc, 32'h0000_3010);

        // Redirect during stall is buffered, applied on release.
        step(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'h0);
        check("stall_pc", bus.pc, 32'h0000_3010);
        check("stall_pend", 32'(bus.redir_pending), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("stall_pc2", bus.pc, 32'h0000_3010);
        check("stall_pend2", 32'(bus.redir_pending), 32'd1);
        run();
        check("release_pc", bus.pc, 32'h0000_5000);
        check("release_pend", 32'(bus.redir_pending), 32'd0);
        run(); check("after_rel", bus.pc, 32'h0000_5004);

        // Live redirect in the release cycle beats the buffered one.
        step(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_6000, 1'b0, 1'b0, 32'h0);
        check("live_pc", bus.pc, 32'h0000_6000);
        check("live_pend", 32'(bus.redir_pending), 32'd0);

        // Exception during stall with pending redirect; eret; both together.
        step(1'b1, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("exc_pc", bus.pc, 32'h0000_4180);
        check("exc_pend", 32'(bus.redir_pending), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3020);
        check("eret_pc", bus.pc, 32'h0000_3020);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3020);
        check("exc_eret_pc", bus.pc, 32'h0000_4180);

        // Wrap-around at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0);
        check("wrap_step2", bus.pc_step2, 32'h0000_0000);
        run(); check("wrap_pc1", bus.pc, 32'hFFFF_FFFC);
        check("wrap_step1", bus.pc_step1, 32'h0000_0000);
        run(); check("wrap_pc2", bus.pc, 32'h0000_0000);

        // Misaligned target, then reset while holding a redirect.
        step(1'b1, 1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0);
        check("mis_pc", bus.pc, 32'h0000_3002);
        check("mis_flag", 32'(bus.misalign), 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
        check("hold_pend", 32'(bus.redir_pending), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h0000_9000, 1'b1, 1'b0, 32'h0);
        check("rst2_pc", bus.pc, 32'h0000_3000);
        check("rst2_pend", 32'(bus.redir_pending), 32'd0);
        check("rst2_mis", 32'(bus.misalign), 32'd0);
        run(); check("rst2_free", bus.pc, 32'h0000_3004);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic        rn, st, rv, ex, er;
            logic [31:0] tgt, ep;
            rn  = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 40);
            rv  = ($urandom_range(0, 99) < 30);
            ex  = ($urandom_range(0, 99) < 4);
            er  = ($urandom_range(0, 99) < 5);
            tgt = $urandom;
            ep  = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ep[1:0]  = 2'b00;
            step(rn, st, rv, tgt, ex, er, ep);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
